// File: rtl/bcd_line_writer_pkg.sv
// Shared types and helpers for the BCD line writer: FSM state encoding,
// full-scale BCD constant and the digit-to-column mapping.
package bcd_line_writer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // All-F field pattern for a 5-digit field; marks "no value" in blank-on-F fields.
  localparam logic [19:0] MAX_BCDCOUNT = 20'hFFFFF;

  // Digits at or above the decimal point index sit one column higher,
  // leaving the template's decimal point glyph untouched.
  function automatic logic [7:0] col_index(input logic [7:0] field_pos,
                                           input logic [7:0] digit,
                                           input logic [7:0] dp_index);
    return field_pos + digit + ((digit >= dp_index) ? 8'd1 : 8'd0);
  endfunction

endpackage

// File: rtl/bcd_line_writer_if.sv
// Request/response bundle of the line writer: line request, glyph ROM port
// and the composed-line result.
interface bcd_line_writer_if #(
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned DIGITS     = 5,
  parameter int unsigned LINE_CHARS = 46
);

  logic                           start;
  logic [3:0]                     row_addr;
  logic [LINE_CHARS*8-1:0]        template_line;
  logic [NUM_FIELDS*DIGITS*4-1:0] bcd_in;
  logic [7:0]                     char_addr;
  logic [7:0]                     char_data;
  logic [LINE_CHARS*8-1:0]        line_out;
  logic                           busy;
  logic                           done;

  // Requester side: issues lines and provides the glyph ROM response.
  modport master (
    output start, row_addr, template_line, bcd_in, char_data,
    input  char_addr, line_out, busy, done
  );

  // Line writer side.
  modport slave (
    input  start, row_addr, template_line, bcd_in, char_data,
    output char_addr, line_out, busy, done
  );

endinterface

// File: rtl/bcd_line_writer_lead_zero_mask.sv
// Per-field leading-zero mask: bit d set when digit d is at or above the
// decimal point and it and every more significant digit are zero.
module bcd_line_writer_lead_zero_mask #(
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned DP_INDEX = 2
) (
  input  logic [DIGITS*4-1:0] digits_i,
  output logic [DIGITS-1:0]   mask_o
);

  logic hi_zero;

  // Walk from the most significant digit down, accumulating "all zero so far".
  always_comb begin
    mask_o  = '0;
    hi_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      hi_zero   = hi_zero & (digits_i[d*4 +: 4] == 4'd0);
      mask_o[d] = (d >= int'(DP_INDEX)) && hi_zero;
    end
  end

endmodule

// File: rtl/bcd_line_writer.sv
// Renders packed BCD fields into a glyph-row bitmap line, one external ROM
// lookup per digit, overlaying the result on a static template line.
module bcd_line_writer
  import bcd_line_writer_pkg::*;
#(
  parameter int unsigned               NUM_FIELDS    = 4,
  parameter int unsigned               DIGITS        = 5,
  parameter int unsigned               LINE_CHARS    = 46,
  parameter logic [NUM_FIELDS*8-1:0]   FIELD_POS     = {8'd0, 8'd15, 8'd24, 8'd39},
  parameter int unsigned               DP_INDEX      = 2,
  parameter logic [NUM_FIELDS-1:0]     BLANK_ON_ZERO = 4'b1000,
  parameter bit                        LZ_SUPPRESS   = 1'b1,
  parameter int unsigned               ROM_LATENCY   = 2
) (
  input logic              clock,
  input logic              reset_n,
  bcd_line_writer_if.slave bus
);

  localparam int unsigned FieldW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned DigitW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FieldBits = DIGITS * 4;
  localparam int unsigned BcdBits   = NUM_FIELDS * FieldBits;
  localparam int unsigned LineBits  = LINE_CHARS * 8;

  state_e                state_q, state_d;
  logic [FieldW-1:0]     field_q, field_d;
  logic [DigitW-1:0]     digit_q, digit_d;
  logic [1:0]            drain_q, drain_d;
  logic [BcdBits-1:0]    bcd_q, bcd_d;
  logic [3:0]            row_q, row_d;
  logic [LineBits-1:0]   line_q, line_d;
  logic [ROM_LATENCY-1:0] vld_q;
  logic [7:0]            col_q [ROM_LATENCY];

  logic [FieldBits-1:0]  cur_field;
  logic [7:0]            cur_pos;
  logic                  cur_boz;
  logic [3:0]            cur_digit;
  logic                  cur_supp;
  logic [DIGITS-1:0]     lz_mask;
  logic                  field_blank;
  logic                  last_field;
  logic                  issue_vld;
  logic [7:0]            issue_col;
  logic [7:0]            char_addr;

  // Select the field under work from the snapshot.
  always_comb begin
    cur_field = '0;
    cur_pos   = '0;
    cur_boz   = 1'b0;
    for (int f = 0; f < int'(NUM_FIELDS); f++) begin
      if (field_q == FieldW'(f)) begin
        cur_field = bcd_q[f*FieldBits +: FieldBits];
        cur_pos   = FIELD_POS[f*8 +: 8];
        cur_boz   = BLANK_ON_ZERO[f];
      end
    end
  end

  bcd_line_writer_lead_zero_mask #(
    .DIGITS   (DIGITS),
    .DP_INDEX (DP_INDEX)
  ) u_lead_zero_mask (
    .digits_i (cur_field),
    .mask_o   (lz_mask)
  );

  always_comb begin
    cur_digit = '0;
    cur_supp  = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (digit_q == DigitW'(d)) begin
        cur_digit = cur_field[d*4 +: 4];
        cur_supp  = LZ_SUPPRESS && lz_mask[d];
      end
    end
  end

  assign field_blank = cur_boz ? (cur_field == '0) : (&cur_field);
  assign last_field  = (field_q == FieldW'(NUM_FIELDS - 1));
  assign issue_col   = col_index(cur_pos, 8'(digit_q), 8'(DP_INDEX));

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    digit_d   = digit_q;
    drain_d   = drain_q;
    bcd_d     = bcd_q;
    row_d     = row_q;
    line_d    = line_q;
    issue_vld = 1'b0;
    char_addr = '0;

    // ROM data arriving at the end of the column pipeline lands in the line.
    if (vld_q[ROM_LATENCY-1]) begin
      for (int k = 0; k < int'(LINE_CHARS); k++) begin
        if (col_q[ROM_LATENCY-1] == 8'(k)) begin
          line_d[k*8 +: 8] = bus.char_data;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          line_d  = bus.template_line;
          bcd_d   = bus.bcd_in;
          row_d   = bus.row_addr;
          field_d = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (field_blank) begin
          if (last_field) begin
            state_d = StDone;
          end else begin
            field_d = field_q + 1'b1;
          end
        end else begin
          digit_d = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        char_addr = {cur_digit, row_q};
        // Suppressed digits still spend their cycle so timing stays fixed.
        issue_vld = !cur_supp;
        if (digit_q == DigitW'(DIGITS - 1)) begin
          drain_d = '0;
          state_d = StDrain;
        end else begin
          digit_d = digit_q + 1'b1;
        end
      end
      StDrain: begin
        if (drain_q == 2'(ROM_LATENCY - 1)) begin
          if (last_field) begin
            state_d = StDone;
          end else begin
            field_d = field_q + 1'b1;
            state_d = StCheck;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      field_q <= '0;
      digit_q <= '0;
      drain_q <= '0;
      bcd_q   <= '0;
      row_q   <= '0;
      line_q  <= '0;
      vld_q   <= '0;
      for (int k = 0; k < int'(ROM_LATENCY); k++) begin
        col_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      digit_q  <= digit_d;
      drain_q  <= drain_d;
      bcd_q    <= bcd_d;
      row_q    <= row_d;
      line_q   <= line_d;
      vld_q[0] <= issue_vld;
      col_q[0] <= issue_col;
      for (int k = 1; k < int'(ROM_LATENCY); k++) begin
        vld_q[k] <= vld_q[k-1];
        col_q[k] <= col_q[k-1];
      end
    end
  end

  assign bus.char_addr = char_addr;
  assign bus.line_out  = line_q;
  assign bus.busy      = (state_q == StCheck) || (state_q == StIssue) || (state_q == StDrain);
  assign bus.done      = (state_q == StDone);

endmodule

// File: doc/bcd_line_writer.md
BCD_LINE_WRITER -- requirements
Module: bcd_line_writer

Interface
REQ-001 Parameter NUM_FIELDS, default 4: number of BCD fields rendered per line.
REQ-002 Parameter DIGITS, default 5: BCD digits per field; digit 0 is least significant.
REQ-003 Parameter LINE_CHARS, default 46: line width in 8-bit glyph columns; char k occupies bits [8k+7:8k].
REQ-004 Parameter FIELD_POS, default {8'd0,8'd15,8'd24,8'd39} (field3..field0): char column of digit 0 of each field.
REQ-005 Parameter DP_INDEX, default 2: digits with index >= DP_INDEX are shifted one column up, leaving a template gap for the decimal point.
REQ-006 Parameter BLANK_ON_ZERO, default 4'b1000: bit i set means field i is blank when all digits are 0; clear means blank when all digits are 4'hF.
REQ-007 Parameter LZ_SUPPRESS, default 1: enables leading-zero suppression.
REQ-008 Parameter ROM_LATENCY, default 2: glyph ROM read latency in cycles, 1..4.
REQ-009 clock  in  1  sole clock; reset is asynchronous and active-low.
REQ-010 reset_n  in  1  asynchronous active-low reset.
REQ-011 start  in  1  single-cycle request; sampled only in IDLE.
REQ-012 row_addr  in  4  glyph row of the line being built.
REQ-013 template_line  in  LINE_CHARS*8  static line bitmap (labels, blanks).
REQ-014 bcd_in  in  NUM_FIELDS*DIGITS*4  packed fields, field 0 in the LSBs.
REQ-015 char_addr  out  8  glyph ROM address = {digit, row_addr}.
REQ-016 char_data  in  8  glyph ROM data, valid ROM_LATENCY cycles after char_addr.
REQ-017 line_out  out  LINE_CHARS*8  composed line, registered.
REQ-018 busy  out  1  high from the cycle after start is accepted until done.
REQ-019 done  out  1  one-cycle pulse; line_out is complete and stable.

Function
REQ-020 FSM states: IDLE, CHECK, ISSUE, DRAIN, DONE.
REQ-021 IDLE with start=1: line_out<=template_line; bcd_in and row_addr snapshotted; field index<=0; go to CHECK.
REQ-022 CHECK lasts 1 cycle: a blank field (REQ-006) goes to the next field's CHECK, or DONE after the last field; otherwise ISSUE.
REQ-023 ISSUE lasts DIGITS cycles, driving char_addr for digits 0..DIGITS-1 in order, one per cycle.
REQ-024 DRAIN lasts ROM_LATENCY cycles, then next field's CHECK, or DONE after the last field.
REQ-025 Each char_data is written to column FIELD_POS[f]+d+(d>=DP_INDEX) exactly ROM_LATENCY cycles after its address, via a valid/column shift pipeline.
REQ-026 With LZ_SUPPRESS=1: digit d >= DP_INDEX whose digits d..DIGITS-1 are all zero is not written, so the template column is kept; its issue cycle is still consumed.
REQ-027 Digits 10..15 are looked up unmodified (address {digit,row}).
REQ-028 Timing: start in cycle 0; done in cycle 1 + NUM_FIELDS + nb*(DIGITS+ROM_LATENCY), where nb is the count of non-blank fields.
REQ-029 DONE lasts 1 cycle with done=1, busy=0, then IDLE; start is ignored outside IDLE, including during DONE.
REQ-030 Changes to bcd_in, row_addr and template_line during busy do not affect the current line.
REQ-031 line_out holds its value between done and the next accepted start.

Reset
REQ-032 reset_n low: state=IDLE, line_out=0, char_addr=0, busy=0, done=0, pipeline valids=0.
REQ-033 Reset mid-operation aborts without a done pulse; the first start after release runs a full line.

Structure
REQ-034 The shared package holds the FSM state enum, MAX_BCDCOUNT (20'hFFFFF), and the column-index function of REQ-025.
REQ-035 One sub-module, lead_zero_mask: combinational per-field suppress mask from DIGITS and DP_INDEX.
REQ-036 The glyph ROM is external; the parent wires char_addr/char_data to the existing char_rom.

Verification
REQ-037 Defaults, row 3, fields 0..3 = 00123, 00045, 10000, 00007, template all 8'h20 -> done at cycle 33; field0 columns 39,40,42 hold glyphs 3,2,1 for row 3; columns 43,44 stay 8'h20.
REQ-038 Fields 0..2 = 20'hFFFFF, field 3 = 0 -> done at cycle 5; no column changes; line_out equals template.
REQ-039 LZ_SUPPRESS=0, field1 = 00000 -> columns 24,25,27,28,29 get glyph 0.
REQ-040 ROM_LATENCY=4, all fields 99999 -> done at cycle 41; every digit column gets glyph 9, none misaligned.
REQ-041 Assert reset_n low at cycle 10 of a run -> all outputs 0, no done; the next start completes normally.
REQ-042 Pulse start at cycles 5 and at the done cycle -> both ignored; exactly one done pulse.
